// File: rtl/rv32i_types.sv
// Shared RV32I decode and dispatch types: station classes, decoded
// instruction fields and the micro-op handed to the reservation stations.
package rv32i_types;

    localparam int NUM_RS_MAX   = 4;
    localparam int UOP_TAG_BITS = 6;
    localparam int UOP_ROB_BITS = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        RS_ALU = 2'd0,
        RS_MUL = 2'd1,
        RS_DIV = 2'd2,
        RS_LSU = 2'd3
    } rs_class_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd_s;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        rs_class_e   rs_class;
        logic        needs_pd;
    } decode_info_t;

    typedef struct packed {
        decode_info_t            info;
        logic [UOP_TAG_BITS-1:0] pd;
        logic [UOP_TAG_BITS-1:0] ps1;
        logic                    ps1_valid;
        logic [UOP_TAG_BITS-1:0] ps2;
        logic                    ps2_valid;
        logic [UOP_ROB_BITS-1:0] rob_num;
    } dispatch_uop_t;

    // x0 is never renamed, and branches/stores have no destination.
    function automatic logic writes_rd(logic [6:0] opcode, logic [4:0] rd);
        return (rd != 5'd0) && (opcode != OPC_BRANCH) && (opcode != OPC_STORE);
    endfunction

endpackage

// File: rtl/dispatch_decode.sv
// Combinational decode: splits the instruction into fields, forms the
// immediate and picks the reservation station class.
module dispatch_decode
    import rv32i_types::*;
#(
    parameter int NUM_RS = 3
) (
    input  logic [31:0]  inst_i,
    output decode_info_t info_o
);

    logic [6:0] opcode;
    assign opcode = inst_i[6:0];

    always_comb begin
        info_o          = '0;
        info_o.opcode   = opcode;
        info_o.rd_s     = inst_i[11:7];
        info_o.rs1_s    = inst_i[19:15];
        info_o.rs2_s    = inst_i[24:20];
        info_o.funct3   = inst_i[14:12];
        info_o.funct7   = inst_i[31:25];
        info_o.needs_pd = writes_rd(opcode, inst_i[11:7]);

        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                info_o.imm = {{20{inst_i[31]}}, inst_i[31:20]};
            OPC_STORE:
                info_o.imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            OPC_BRANCH:
                info_o.imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                              inst_i[30:25], inst_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                info_o.imm = {inst_i[31:12], 12'd0};
            OPC_JAL:
                info_o.imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                              inst_i[20], inst_i[30:21], 1'b0};
            default:
                info_o.imm = 32'd0;
        endcase

        // funct3[2] separates the divide group from the multiply group.
        if (opcode == OPC_OP && inst_i[31:25] == FUNCT7_MULDIV) begin
            info_o.rs_class = inst_i[14] ? RS_DIV : RS_MUL;
        end else if (NUM_RS > 3 && (opcode == OPC_LOAD || opcode == OPC_STORE)) begin
            info_o.rs_class = RS_LSU;
        end else begin
            info_o.rs_class = RS_ALU;
        end
    end

endmodule

// File: rtl/dispatch_stage.sv
// Rename/dispatch stage: pops the instruction queue, renames through the
// RAT and free list, and holds one micro-op until the ROB and station accept it.
module dispatch_stage
    import rv32i_types::*;
#(
    parameter int PHYS_REG_BITS = 6,
    parameter int ROB_IDX_BITS  = 5,
    parameter int NUM_RS        = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [31:0]              iq_inst,
    input  logic                     iq_valid,
    output logic                     iq_dequeue,
    input  logic [PHYS_REG_BITS-1:0] fl_pd,
    input  logic                     fl_empty,
    output logic                     fl_dequeue,
    output logic [4:0]               rat_rs1,
    output logic [4:0]               rat_rs2,
    output logic [4:0]               rat_rd,
    input  logic [PHYS_REG_BITS-1:0] rat_ps1,
    input  logic [PHYS_REG_BITS-1:0] rat_ps2,
    input  logic                     rat_ps1_valid,
    input  logic                     rat_ps2_valid,
    output logic                     rat_we,
    output logic [PHYS_REG_BITS-1:0] rat_pd,
    input  logic                     cdb_valid,
    input  logic [PHYS_REG_BITS-1:0] cdb_pd,
    input  logic                     rob_full,
    input  logic [ROB_IDX_BITS-1:0]  rob_tail,
    output logic                     rob_enqueue,
    input  logic [NUM_RS-1:0]        rs_full,
    output logic [NUM_RS-1:0]        rs_push,
    output dispatch_uop_t            uop_out,
    output logic [31:0]              stall_cycles
);

    decode_info_t dec;

    dispatch_decode #(.NUM_RS(NUM_RS)) u_decode (
        .inst_i (iq_inst),
        .info_o (dec)
    );

    logic                     out_valid_q, out_valid_d;
    decode_info_t             info_q, info_d;
    logic [PHYS_REG_BITS-1:0] pd_q, pd_d;
    logic [PHYS_REG_BITS-1:0] ps1_q, ps1_d;
    logic [PHYS_REG_BITS-1:0] ps2_q, ps2_d;
    logic                     ps1_v_q, ps1_v_d;
    logic                     ps2_v_q, ps2_v_d;
    logic [31:0]              stall_q, stall_d;

    logic station_full;
    logic out_fire;
    logic in_fire;

    function automatic logic tag_ready(logic [PHYS_REG_BITS-1:0] tag,
                                       logic                     bc_valid,
                                       logic [PHYS_REG_BITS-1:0] bc_tag);
        return (tag == '0) || (bc_valid && bc_tag == tag);
    endfunction

    // Only the station the held uop targets can back-pressure it.
    always_comb begin
        station_full = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (info_q.rs_class == rs_class_e'(i)) station_full = rs_full[i];
        end
    end

    assign out_fire = !rst && !flush && out_valid_q && !rob_full && !station_full;
    assign in_fire  = !rst && !flush && iq_valid && (!out_valid_q || out_fire)
                      && (!dec.needs_pd || !fl_empty);

    always_comb begin
        info_d  = info_q;
        pd_d    = pd_q;
        ps1_d   = ps1_q;
        ps2_d   = ps2_q;
        ps1_v_d = ps1_v_q || tag_ready(ps1_q, cdb_valid, cdb_pd);
        ps2_v_d = ps2_v_q || tag_ready(ps2_q, cdb_valid, cdb_pd);
        if (in_fire) begin
            // RAT outputs are the mappings before this instruction's own write.
            info_d  = dec;
            pd_d    = dec.needs_pd ? fl_pd : '0;
            ps1_d   = rat_ps1;
            ps2_d   = rat_ps2;
            ps1_v_d = rat_ps1_valid || tag_ready(rat_ps1, cdb_valid, cdb_pd);
            ps2_v_d = rat_ps2_valid || tag_ready(rat_ps2, cdb_valid, cdb_pd);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)         out_valid_d = 1'b0;
        else if (in_fire)  out_valid_d = 1'b1;
        else if (out_fire) out_valid_d = 1'b0;

        stall_d = stall_q;
        if (out_valid_q && !out_fire && !flush && stall_q != '1) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            stall_q     <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
        info_q  <= info_d;
        pd_q    <= pd_d;
        ps1_q   <= ps1_d;
        ps2_q   <= ps2_d;
        ps1_v_q <= ps1_v_d;
        ps2_v_q <= ps2_v_d;
    end

    assign iq_dequeue   = in_fire;
    assign fl_dequeue   = in_fire && dec.needs_pd;
    assign rat_we       = in_fire && dec.needs_pd;
    assign rat_pd       = fl_pd;
    assign rat_rd       = dec.rd_s;
    assign rat_rs1      = dec.rs1_s;
    assign rat_rs2      = dec.rs2_s;
    assign rob_enqueue  = out_fire;
    assign stall_cycles = stall_q;

    always_comb begin
        rs_push = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            rs_push[i] = out_fire && (info_q.rs_class == rs_class_e'(i));
        end
    end

    always_comb begin
        uop_out           = '0;
        uop_out.info      = info_q;
        uop_out.pd        = UOP_TAG_BITS'(pd_q);
        uop_out.ps1       = UOP_TAG_BITS'(ps1_q);
        uop_out.ps1_valid = ps1_v_q;
        uop_out.ps2       = UOP_TAG_BITS'(ps2_q);
        uop_out.ps2_valid = ps2_v_q;
        uop_out.rob_num   = UOP_ROB_BITS'(rob_tail);
    end

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage with a cycle-level reference model.
module tb_dispatch_stage;
    import rv32i_types::*;

    localparam int PRB = 6;
    localparam int RIB = 5;
    localparam int NRS = 3;

    localparam logic [31:0] ADD_X3 = 32'h002081B3;
    localparam logic [31:0] MUL_X5 = 32'h027302B3;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic            clk = 1'b0;
    logic            rst, flush;
    logic [31:0]     iq_inst;
    logic            iq_valid, iq_dequeue;
    logic [PRB-1:0]  fl_pd;
    logic            fl_empty, fl_dequeue;
    logic [4:0]      rat_rs1, rat_rs2, rat_rd;
    logic [PRB-1:0]  rat_ps1, rat_ps2;
    logic            rat_ps1_valid, rat_ps2_valid;
    logic            rat_we;
    logic [PRB-1:0]  rat_pd;
    logic            cdb_valid;
    logic [PRB-1:0]  cdb_pd;
    logic            rob_full;
    logic [RIB-1:0]  rob_tail;
    logic            rob_enqueue;
    logic [NRS-1:0]  rs_full, rs_push;
    dispatch_uop_t   uop_out;
    logic [31:0]     stall_cycles;

    always #5 clk = ~clk;

    dispatch_stage #(.PHYS_REG_BITS(PRB), .ROB_IDX_BITS(RIB), .NUM_RS(NRS)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iq_inst(iq_inst), .iq_valid(iq_valid), .iq_dequeue(iq_dequeue),
        .fl_pd(fl_pd), .fl_empty(fl_empty), .fl_dequeue(fl_dequeue),
        .rat_rs1(rat_rs1), .rat_rs2(rat_rs2), .rat_rd(rat_rd),
        .rat_ps1(rat_ps1), .rat_ps2(rat_ps2),
        .rat_ps1_valid(rat_ps1_valid), .rat_ps2_valid(rat_ps2_valid),
        .rat_we(rat_we), .rat_pd(rat_pd),
        .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
        .rob_full(rob_full), .rob_tail(rob_tail), .rob_enqueue(rob_enqueue),
        .rs_full(rs_full), .rs_push(rs_push),
        .uop_out(uop_out), .stall_cycles(stall_cycles)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: at most one uop held; it leaves when ROB and its station have room.
    function automatic int model_cls(logic [31:0] inst);
        if (inst[6:0] == 7'h33 && inst[31:25] == 7'd1) return inst[14] ? 2 : 1;
        if (NRS > 3 && (inst[6:0] == 7'h03 || inst[6:0] == 7'h23)) return 3;
        return 0;
    endfunction

    function automatic bit model_np(logic [31:0] inst);
        return inst[11:7] != 0 && inst[6:0] != 7'h63 && inst[6:0] != 7'h23;
    endfunction

    bit          checking = 1'b0;
    bit          m_valid = 1'b0, n_valid;
    int          m_cls = 0, n_cls;
    int          m_pd = 0, m_ps1 = 0, m_ps2 = 0, n_pd, n_ps1, n_ps2;
    bit          m_ps1v = 1'b0, m_ps2v = 1'b0, n_ps1v, n_ps2v;
    longint      m_stall = 0, n_stall;
    bit          e_ofire, e_ifire, e_np;
    logic [NRS-1:0] e_push;

    always @(negedge clk) begin
        if (checking) begin
            e_np    = model_np(iq_inst);
            e_ofire = !rst && m_valid && !flush && !rob_full && !rs_full[m_cls];
            e_ifire = !rst && iq_valid && !flush && (!m_valid || e_ofire) && (!e_np || !fl_empty);
            e_push  = e_ofire ? NRS'(1 << m_cls) : '0;

            chk("iq_dequeue", iq_dequeue, e_ifire);
            chk("fl_dequeue", fl_dequeue, e_ifire && e_np);
            chk("rat_we", rat_we, e_ifire && e_np);
            chk("rat_rs1", rat_rs1, iq_inst[19:15]);
            chk("rat_rs2", rat_rs2, iq_inst[24:20]);
            if (e_ifire) begin
                chk("rat_rd", rat_rd, iq_inst[11:7]);
                chk("rat_pd", rat_pd, fl_pd);
            end
            chk("rob_enqueue", rob_enqueue, e_ofire);
            chk("rs_push", rs_push, e_push);
            chk("stall_cycles", stall_cycles, m_stall);
            if (e_ofire) begin
                chk("uop_pd", uop_out.pd, m_pd);
                chk("uop_ps1", uop_out.ps1, m_ps1);
                chk("uop_ps1_valid", uop_out.ps1_valid, m_ps1v);
                chk("uop_ps2", uop_out.ps2, m_ps2);
                chk("uop_ps2_valid", uop_out.ps2_valid, m_ps2v);
                chk("uop_rob_num", uop_out.rob_num, rob_tail);
                chk("uop_class", uop_out.info.rs_class, m_cls);
            end

            n_valid = m_valid; n_cls = m_cls; n_pd = m_pd;
            n_ps1 = m_ps1; n_ps2 = m_ps2; n_ps1v = m_ps1v; n_ps2v = m_ps2v;
            n_stall = m_stall;
            if (rst) begin
                n_valid = 1'b0;
                n_stall = 0;
            end else begin
                if (m_valid && !e_ofire && !flush && m_stall != 64'hFFFF_FFFF) n_stall = m_stall + 1;
                if (cdb_valid && cdb_pd == m_ps1) n_ps1v = 1'b1;
                if (cdb_valid && cdb_pd == m_ps2) n_ps2v = 1'b1;
                if (flush) begin
                    n_valid = 1'b0;
                end else if (e_ifire) begin
                    n_valid = 1'b1;
                    n_cls   = model_cls(iq_inst);
                    n_pd    = e_np ? int'(fl_pd) : 0;
                    n_ps1   = rat_ps1;
                    n_ps2   = rat_ps2;
                    n_ps1v  = rat_ps1_valid || rat_ps1 == 0 || (cdb_valid && cdb_pd == rat_ps1);
                    n_ps2v  = rat_ps2_valid || rat_ps2 == 0 || (cdb_valid && cdb_pd == rat_ps2);
                end else if (e_ofire) begin
                    n_valid = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (checking) begin
            m_valid = n_valid; m_cls = n_cls; m_pd = n_pd;
            m_ps1 = n_ps1; m_ps2 = n_ps2; m_ps1v = n_ps1v; m_ps2v = n_ps2v;
            m_stall = n_stall;
        end
    end

    int enq_cnt;

    initial begin
        rst = 1'b1; flush = 1'b0;
        iq_inst = ADD_X3; iq_valid = 1'b1;
        fl_pd = 6'd9; fl_empty = 1'b0;
        rat_ps1 = 6'd4; rat_ps1_valid = 1'b1;
        rat_ps2 = 6'd5; rat_ps2_valid = 1'b1;
        cdb_valid = 1'b0; cdb_pd = '0;
        rob_full = 1'b0; rob_tail = '0; rs_full = '0;
        checking = 1'b1;

        // Reset holds every strobe low even with a valid queue head.
        tick(); tick();
        @(negedge clk);
        chk("reset_iq_dequeue", iq_dequeue, 0);
        chk("reset_stall", stall_cycles, 0);
        tick();
        rst = 1'b0; iq_valid = 1'b0;
        tick();

        // add x3,x1,x2 renamed to p9, pushed to ALU next cycle.
        rob_tail = 5'd7; iq_inst = ADD_X3; iq_valid = 1'b1; fl_pd = 6'd9;
        @(negedge clk);
        chk("add_fl_dequeue", fl_dequeue, 1);
        chk("add_rat_we", rat_we, 1);
        chk("add_rat_rd", rat_rd, 3);
        chk("add_rat_pd", rat_pd, 9);
        tick();
        iq_valid = 1'b0;
        @(negedge clk);
        chk("add_rs_push", rs_push, 3'b001);
        chk("add_rob_enqueue", rob_enqueue, 1);
        chk("add_uop_pd", uop_out.pd, 9);
        chk("add_rob_num", uop_out.rob_num, 7);
        tick();

        // mul blocked by a full MUL station; the following add must wait.
        iq_inst = MUL_X5; iq_valid = 1'b1; fl_pd = 6'd10; rs_full = 3'b010;
        @(negedge clk);
        chk("mul_accept", iq_dequeue, 1);
        tick();
        iq_inst = ADD_X3; fl_pd = 6'd11;
        @(negedge clk);
        chk("add_blocked", iq_dequeue, 0);
        chk("mul_held_push", rs_push, 3'b000);
        tick(); tick(); tick();
        @(negedge clk);
        chk("mul_stall_count", stall_cycles, 3);
        tick();
        rs_full = 3'b000;
        @(negedge clk);
        chk("mul_release_push", rs_push, 3'b010);
        chk("add_follows", iq_dequeue, 1);
        tick();
        rs_full = 3'b010; iq_valid = 1'b0;
        @(negedge clk);
        chk("other_class_full", rs_push, 3'b001);
        tick();
        rs_full = 3'b000;

        // addi x0 needs no physical register, so an empty free list is fine.
        iq_inst = NOP; iq_valid = 1'b1; fl_empty = 1'b1; fl_pd = 6'd13;
        @(negedge clk);
        chk("nop_iq_dequeue", iq_dequeue, 1);
        chk("nop_fl_dequeue", fl_dequeue, 0);
        tick();
        iq_valid = 1'b0; fl_empty = 1'b0;
        @(negedge clk);
        chk("nop_push", rs_push, 3'b001);
        chk("nop_pd", uop_out.pd, 0);
        tick();

        // Operand wakeup while held.
        iq_inst = ADD_X3; iq_valid = 1'b1; fl_pd = 6'd14;
        rat_ps1 = 6'd12; rat_ps1_valid = 1'b0; rob_full = 1'b1;
        tick();
        iq_valid = 1'b0;
        @(negedge clk);
        chk("wake_before", uop_out.ps1_valid, 0);
        chk("wake_ps1", uop_out.ps1, 12);
        tick();
        cdb_valid = 1'b1; cdb_pd = 6'd12;
        tick();
        cdb_valid = 1'b0;
        @(negedge clk);
        chk("wake_after", uop_out.ps1_valid, 1);
        tick();

        // Capture-cycle bypass and tag-0 readiness.
        rob_full = 1'b0; iq_valid = 1'b1; fl_pd = 6'd15;
        rat_ps1 = 6'd0; rat_ps1_valid = 1'b0;
        rat_ps2 = 6'd20; rat_ps2_valid = 1'b0;
        cdb_valid = 1'b1; cdb_pd = 6'd20;
        tick();
        iq_valid = 1'b0; cdb_valid = 1'b0; rob_full = 1'b1;
        @(negedge clk);
        chk("bypass_ps2_valid", uop_out.ps2_valid, 1);
        chk("tag0_ps1_valid", uop_out.ps1_valid, 1);
        tick();

        // Flush with a held uop and a valid queue head.
        rob_full = 1'b0; iq_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_no_enqueue", rob_enqueue, 0);
        chk("flush_no_dequeue", iq_dequeue, 0);
        chk("flush_no_push", rs_push, 3'b000);
        tick();
        flush = 1'b0; iq_valid = 1'b0;
        @(negedge clk);
        chk("flush_cleared", rob_enqueue, 0);
        tick();

        // Ten back-to-back ALU ops.
        rat_ps1 = 6'd4; rat_ps1_valid = 1'b1; rat_ps2 = 6'd5; rat_ps2_valid = 1'b1;
        iq_inst = ADD_X3; iq_valid = 1'b1;
        enq_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            if (i == 10) iq_valid = 1'b0;
            rob_tail = RIB'(i);
            @(negedge clk);
            if (i == 0) chk("b2b_first_idle", rob_enqueue, 0);
            else if (rob_enqueue) enq_cnt++;
            tick();
        end
        chk("b2b_enqueue_count", enq_cnt, 10);
        @(negedge clk);
        chk("b2b_drained", rob_enqueue, 0);
        tick();

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dispatch_stage.md
DISPATCH_STAGE -- requirements
Module: dispatch_stage

Interface
REQ-001 Parameter PHYS_REG_BITS, default 6, physical register tag width.
REQ-002 Parameter ROB_IDX_BITS, default 5, ROB index width.
REQ-003 Parameter NUM_RS, default 3, reservation station count: 0 = ALU, 1 = MUL, 2 = DIV, 3 = LSU if present.
REQ-004 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 Ports SHALL be as follows:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  squash held and arriving instruction
- iq_inst  in  32  instruction at the queue head
- iq_valid  in  1  queue not empty
- iq_dequeue  out  1  pop the queue
- fl_pd  in  PHYS_REG_BITS  free-list head
- fl_empty  in  1  free list empty
- fl_dequeue  out  1  pop the free list
- rat_rs1, rat_rs2, rat_rd  out  5 each  architectural indices
- rat_ps1, rat_ps2  in  PHYS_REG_BITS  current mappings
- rat_ps1_valid, rat_ps2_valid  in  1  operand ready
- rat_we  out  1  remap rat_rd to rat_pd
- rat_pd  out  PHYS_REG_BITS  new mapping
- cdb_valid  in  1  broadcast valid
- cdb_pd  in  PHYS_REG_BITS  broadcast tag
- rob_full  in  1  ROB full
- rob_tail  in  ROB_IDX_BITS  next ROB slot
- rob_enqueue  out  1  allocate ROB entry
- rs_full  in  NUM_RS  per-station full
- rs_push  out  NUM_RS  one-hot station write
- uop_out  out  dispatch_uop_t  decode_info_t, pd, ps1/ps2 with valids, rob_num
- stall_cycles  out  32  saturating stall counter

Function
REQ-006 Decode SHALL classify the instruction: op_b_reg with funct7 = 0000001 and funct3 in mul/mulh/mulhsu/mulhu -> MUL; same funct7 with div/divu/rem/remu -> DIV; load/store -> LSU when NUM_RS > 3; everything else -> ALU.
REQ-007 needs_pd SHALL be 1 when rd_s != 0 and the opcode writes rd, i.e. not branch and not store.
REQ-008 in_fire SHALL equal iq_valid && !flush && (!out_valid || out_fire) && (!needs_pd || !fl_empty).
REQ-009 On in_fire: iq_dequeue = 1; fl_dequeue = rat_we = needs_pd; rat_pd = fl_pd; rat_rd = rd_s.
REQ-010 When in_fire is low, iq_dequeue, fl_dequeue and rat_we SHALL all be 0.
REQ-011 rat_rs1 and rat_rs2 SHALL be driven every cycle; operands SHALL capture the pre-write mapping, so rs1 == rd in the same instruction reads the old tag.
REQ-012 On in_fire, the output register SHALL capture decode fields, rs class, ps1/ps2, and pd (0 when !needs_pd) at the next edge, then set out_valid.
REQ-013 ps valid bits SHALL be set if cdb_valid && cdb_pd matches, both at capture (bypass) and every cycle while held.
REQ-014 Tag 0 SHALL always be valid.
REQ-015 out_fire SHALL equal out_valid && !rob_full && !rs_full[class]; a full station of another class SHALL NOT stall dispatch.
REQ-016 On out_fire: rob_enqueue = 1; rs_push = onehot(class); uop_out.rob_num = rob_tail.
REQ-017 When out_fire is low, rob_enqueue and rs_push SHALL be 0.
REQ-018 out_fire and in_fire in the same cycle SHALL give back-to-back throughput of one instruction per cycle.
REQ-019 flush SHALL clear out_valid at the next edge, suppress in_fire and out_fire that cycle, and leave RAT/free-list recovery to their owners.
REQ-020 stall_cycles SHALL increment, saturating at 0xFFFFFFFF, on each cycle with out_valid && !out_fire && !flush.

Reset
REQ-021 On rst: out_valid = 0 and stall_cycles = 0; all strobes are 0 in the same cycle; uop_out contents are don't-care.
REQ-022 rst SHALL take priority over flush and all fires.

Structure
REQ-023 rs_class_e, dispatch_uop_t, and the NUM_RS_MAX = 4 constant SHALL live in rv32i_types, alongside decode_info_t.
REQ-024 Classification and immediate decode SHALL form one combinational sub-module, dispatch_decode; all state stays in dispatch_stage.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- add x3,x1,x2 (0x002081B3), fl_pd = 9, all free -> in cycle 0, fl_dequeue/rat_we with rd = 3, pd = 9; in cycle 1, rs_push = 001, rob_enqueue.
- mul fires while rs_full = 010, then add follows -> mul holds and stall_cycles counts; add is not accepted until mul leaves; release rs_full[1] -> push 010.
- addi x0,x0,0 with fl_empty = 1 -> dispatches with pd = 0 and fl_dequeue = 0.
- Held uop with ps1 = 12 invalid, cdb_pd = 12 pulse -> ps1_valid = 1 next cycle; capture-cycle bypass is also checked.
- flush while out_valid = 1 and iq_valid = 1 -> no push, no dequeue, out_valid = 0 next cycle.
- Ten back-to-back ALU ops -> ten consecutive rob_enqueue cycles.
